// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU issue-slot arbiter: the request payload, ALU op encodings
// and the requester count limit.
package cva5_types;

   localparam int MAX_ALU_REQ = 4;
   localparam int ALU_TAG_W   = $clog2(MAX_ALU_REQ);

   typedef enum logic [1:0] {
      CONSTANT = 2'b00,
      ADD_SUB  = 2'b01,
      SLT      = 2'b10,
      SHIFT    = 2'b11
   } alu_op_t;

   typedef struct packed {
      alu_op_t     op;
      logic [2:0]  fn3;
      logic        subtract;
      logic        imm_type;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [11:0] imm12;
   } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU issue and ALU writeback signals of the shared ALU slot.
// slave = the arbiter, master = the requesters/ALU side.
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0]  req_valid;
   logic [NUM_REQ-1:0]  req_ready;
   cva5_types::alu_req_t req_op [NUM_REQ];
   logic                alu_valid;
   logic                alu_ready;
   cva5_types::alu_req_t alu_op;
   logic                alu_done;
   logic [31:0]         alu_result;
   logic [NUM_REQ-1:0]  resp_valid;
   logic [31:0]         resp_data;
   logic                busy;

   modport slave (
      input  req_valid, req_op, alu_ready, alu_done, alu_result,
      output req_ready, alu_valid, alu_op, resp_valid, resp_data, busy
   );

   modport master (
      output req_valid, req_op, alu_ready, alu_done, alu_result,
      input  req_ready, alu_valid, alu_op, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/alu_share_arbiter_tag_fifo.sv
// In-order FIFO of requester indices for operations issued to the ALU.
// Head entry is readable combinationally so the result can be routed in its return cycle.
module alu_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU issue slot between NUM_REQ requesters via per-requester hold buffers.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module alu_share_arbiter
   import cva5_types::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int FLIGHT_DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   alu_share_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FLIGHT_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = ALU_TAG_W;

   logic [NUM_REQ-1:0] r_buf_valid;
   alu_req_t           r_buf [NUM_REQ];
   logic [CNT_W-1:0]   r_outstanding;
   logic               r_lock;
   logic [IDX_W-1:0]   r_lock_idx;

   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_grant_oh;
   logic [NUM_REQ-1:0] w_req_ready;
   logic [IDX_W-1:0]   w_arb_idx;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [IDX_W-1:0]   w_head;
   logic               w_can_issue;
   logic               w_any;
   logic               w_commit;
   logic               w_pop;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   alu_req_t           w_alu_op;

   // Eligibility uses the registered count, so a same-cycle alu_done never unblocks a full slot.
   assign w_can_issue = (r_outstanding < CNT_W'(FLIGHT_DEPTH)) & ~w_fifo_full;
   assign w_eligible  = r_buf_valid & {NUM_REQ{w_can_issue}};
   assign w_any       = |w_eligible;
   assign w_commit    = w_any & bus.alu_ready;
   assign w_pop       = bus.alu_done & ~w_fifo_empty;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] r_rr_ptr;

   always_comb begin
      int   w_idx;
      logic w_found;
      w_arb_idx = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_found && w_eligible[w_idx]) begin
            w_arb_idx = IDX_W'(w_idx);
            w_found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rr_ptr <= '0;
      else if (w_commit)
         r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
   end
`else
   always_comb begin
      w_arb_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_eligible[k])
            w_arb_idx = IDX_W'(k);
      end
   end
`endif

   // A stalled grant is frozen until accepted, even if a higher-priority buffer fills meanwhile.
   assign w_grant_idx = r_lock ? r_lock_idx : w_arb_idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign w_grant_oh[gi]     = w_any & (w_grant_idx == IDX_W'(gi));
         assign w_req_ready[gi]    = ~r_buf_valid[gi] | (w_grant_oh[gi] & w_commit);
         assign bus.resp_valid[gi] = w_pop & (w_head == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      w_alu_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_oh[i])
            w_alu_op = r_buf[i];
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.alu_valid = w_any;
   assign bus.alu_op    = w_alu_op;
   assign bus.resp_data = bus.alu_result;
   assign bus.busy      = (|r_buf_valid) | (r_outstanding != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_buf_valid[i] <= 1'b0;
            r_buf[i]       <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && w_req_ready[i]) begin
               r_buf_valid[i] <= 1'b1;
               r_buf[i]       <= bus.req_op[i];
            end else if (w_grant_oh[i] && w_commit) begin
               r_buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock        <= 1'b0;
         r_lock_idx    <= '0;
         r_outstanding <= '0;
      end else begin
         r_lock     <= w_any & ~bus.alu_ready;
         r_lock_idx <= w_grant_idx;
         case ({w_commit, w_pop})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   alu_tag_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (FLIGHT_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_commit),
      .i_data  (w_grant_idx),
      .i_pop   (bus.alu_done),
      .o_data  (w_head),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a queue-based reference model.
// Build with or without ALU_ARB_ROUND_ROBIN_EN to match the RTL configuration.
module tb_alu_share_arbiter;
   import cva5_types::*;

   localparam int NR    = 2;
   localparam int DEPTH = 4;

   typedef struct {
      int          due;
      logic [31:0] res;
   } pend_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

   alu_share_arbiter #(.NUM_REQ(NR), .FLIGHT_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit       hv  [NR];
   alu_req_t hop [NR];
   int       tagq [$];
   int       rr = 0;
   bit       lk = 0;
   int       lk_i = 0;

   // ALU model: in-order results after a fixed latency
   pend_t       pend [$];
   int          cyc = 0;
   int          lat = 1;
   int          last_due = 0;
   bit          use_fixed = 0;
   logic [31:0] fixed_res = 32'h0;

   // Requester-side stimulus
   logic [NR-1:0] rv = '0;
   alu_req_t      rop [NR];
   bit            acc [NR];
   bit            ardy = 1'b1;
   int            budget = 1000000;
   int            seq = 0;
   int            gq [$];
   logic [NR-1:0] last_resp;
   logic [31:0]   last_rd;
   alu_req_t      last_op;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   function automatic alu_req_t rand_op(input int r);
      alu_req_t o;
      o.op       = alu_op_t'($urandom_range(0, 3));
      o.fn3      = 3'($urandom);
      o.subtract = 1'($urandom);
      o.imm_type = 1'($urandom);
      o.rs1      = {r[3:0], seq[27:0]};
      o.rs2      = $urandom;
      o.imm12    = 12'($urandom);
      seq++;
      return o;
   endfunction

   function automatic bit model_idle();
      bit any = 0;
      for (int i = 0; i < NR; i++) any |= hv[i];
      return !any && tagq.size() == 0 && pend.size() == 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) hv[i] = 0;
      tagq.delete();
      rr = 0;
      lk = 0;
   endtask

   task automatic step();
      int            g;
      bit            ev, commit, bexp;
      logic [NR-1:0] er, eresp;
      @(negedge clk);
      cyc++;
      bus.req_valid = rv;
      for (int i = 0; i < NR; i++) bus.req_op[i] = rop[i];
      bus.alu_ready = ardy;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.alu_done   = 1'b1;
         bus.alu_result = pend[0].res;
         void'(pend.pop_front());
      end else begin
         bus.alu_done   = 1'b0;
         bus.alu_result = $urandom;
      end
      #1;
      g = -1;
      if (tagq.size() < DEPTH) begin
         if (lk) g = lk_i;
         else
            for (int k = 0; k < NR; k++)
               if (g < 0 && hv[(rr + k) % NR]) g = (rr + k) % NR;
      end
      ev     = (g >= 0);
      commit = ev && ardy;
      for (int i = 0; i < NR; i++) er[i] = !hv[i] || (commit && g == i);
      eresp = '0;
      if (bus.alu_done && tagq.size() > 0) eresp[tagq[0]] = 1'b1;
      bexp = (tagq.size() > 0);
      for (int i = 0; i < NR; i++) bexp |= hv[i];

      chk("alu_valid", bus.alu_valid, ev);
      if (ev) chk("alu_op", bus.alu_op, hop[g]);
      chk("req_ready", bus.req_ready, er);
      chk("resp_valid", bus.resp_valid, eresp);
      chk("resp_data", bus.resp_data, bus.alu_result);
      chk("busy", bus.busy, bexp);
      last_resp = bus.resp_valid;
      last_rd   = bus.resp_data;
      last_op   = bus.alu_op;
      if (bus.alu_valid && ardy) gq.push_back(int'(bus.alu_op.rs1[31:28]));

      if (bus.alu_done && tagq.size() > 0) begin
         $display("[%0d] resp req=%0d data=%h", cyc, tagq[0], bus.alu_result);
         void'(tagq.pop_front());
      end
      if (commit) begin
         pend_t p;
         $display("[%0d] issue req=%0d op=%0d rs1=%h", cyc, g, hop[g].op, hop[g].rs1);
         tagq.push_back(g);
         hv[g] = 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         rr = (g + 1) % NR;
`endif
         p.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         p.res    = use_fixed ? fixed_res : $urandom;
         last_due = p.due;
         pend.push_back(p);
      end
      for (int i = 0; i < NR; i++) begin
         acc[i] = rv[i] && er[i];
         if (acc[i]) begin
            hv[i]  = 1;
            hop[i] = rop[i];
         end
      end
      lk   = ev && !ardy;
      lk_i = g;
   endtask

   task automatic new_reqs(input int pct);
      for (int i = 0; i < NR; i++) begin
         if (!rv[i] || acc[i]) begin
            rv[i] = (budget > 0) && ($urandom_range(0, 99) < pct);
            if (rv[i]) budget--;
            rop[i] = rand_op(i);
         end
      end
   endtask

   task automatic run(input int n, input int pct, input int rdy_pct);
      for (int k = 0; k < n; k++) begin
         ardy = ($urandom_range(0, 99) < rdy_pct);
         step();
         new_reqs(pct);
      end
   endtask

   task automatic drain();
      rv   = '0;
      ardy = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (model_idle()) return;
         step();
      end
      chk("drain_timeout", 1, 0);
   endtask

   initial begin
      bus.req_valid  = '0;
      bus.alu_ready  = 1'b0;
      bus.alu_done   = 1'b0;
      bus.alu_result = 32'hdead_beef;
      for (int i = 0; i < NR; i++) begin
         bus.req_op[i] = '0;
         rop[i]        = '0;
         acc[i]        = 0;
      end
      model_reset();
      #2;
      chk("rst_alu_valid", bus.alu_valid, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req_ready", bus.req_ready, {NR{1'b1}});
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_resp_data", bus.resp_data, 32'hdead_beef);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single request on requester 1, latency 1, result 5
      lat = 1; use_fixed = 1; fixed_res = 32'h5;
      rv = 2'b10; rop[1] = rand_op(1); rop[1].op = ADD_SUB; ardy = 1;
      step();
      rv = '0;
      step();
      chk("single_issue", last_op.rs1[31:28], 1);
      step();
      chk("single_resp_valid", last_resp, 2'b10);
      chk("single_resp_data", last_rd, 32'h5);
      use_fixed = 0;
      drain();

      // Contention: both requesters valid every cycle
      gq.delete();
      rv = 2'b11; rop[0] = rand_op(0); rop[1] = rand_op(1);
      for (int k = 0; k < 8; k++) begin
         ardy = 1;
         step();
         new_reqs(100);
      end
      if (gq.size() < 6) chk("contend_count", gq.size(), 6);
      else
         for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            chk("contend_grant", gq[k], k % 2);
`else
            chk("contend_grant", gq[k], 0);
`endif
         end
      drain();

      // Backpressure: stall requester 1 while requester 0 arrives
      rv = 2'b10; rop[1] = rand_op(1); ardy = 1;
      step();
      rv = 2'b01; rop[0] = rand_op(0); ardy = 0;
      step();
      begin
         alu_req_t held;
         held = last_op;
         chk("bp_grant", held.rs1[31:28], 1);
         rv = '0;
         repeat (2) begin
            step();
            chk("bp_stable", last_op, held);
         end
         gq.delete();
         ardy = 1;
         step();
         chk("bp_one_commit", gq.size(), 1);
         chk("bp_commit_op", last_op, held);
      end
      drain();

      // Full in-flight: latency 10, five requests
      lat = 10; budget = 5;
      new_reqs(100);
      run(60, 100, 100);
      budget = 1000000;
      drain();

      // Random traffic at several latencies
      lat = 1;
      run(200, 60, 70);
      drain();
      lat = 3;
      run(200, 70, 85);
      drain();
      lat = 6;
      run(150, 80, 60);
      drain();

      // Reset with three operations in flight
      lat = 10; budget = 3;
      new_reqs(100);
      for (int n = 0; n < 30 && tagq.size() < 3; n++) begin
         ardy = 1;
         step();
         new_reqs(100);
      end
      chk("rst_inflight", tagq.size(), 3);
      budget = 1000000;
      rv = '0;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_alu_valid", bus.alu_valid, 0);
      chk("mid_rst_resp_valid", bus.resp_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_req_ready", bus.req_ready, {NR{1'b1}});
      chk("mid_rst_alu_op", bus.alu_op, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ardy = 1;
      for (int n = 0; n < 40 && pend.size() > 0; n++) step();
      chk("stale_pend_left", pend.size(), 0);
      run(100, 60, 80);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares a single ALU issue slot between up to four requesters: the main issue stage plus auxiliary requesters such as the GC unit (PC+4 for ifence) and the branch unit (constant-ALU address arithmetic). Each requester gets a one-entry hold buffer, and a grant arbiter selects one buffered request per cycle. An in-order tag FIFO routes each ALU result back to the requester that issued it. The block sits between the requesters and the ALU issue/writeback interface.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- FLIGHT_DEPTH, 4, maximum ALU operations in flight (power of two, 2..8)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i presents an operation
- req_ready  out  NUM_REQ  requester i may hand over an operation this cycle
- req_op  in  NUM_REQ x alu_req_t  operation: op, fn3, subtract, imm_type, rs1, rs2, imm12
- alu_valid  out  1  operation presented to the ALU
- alu_ready  in  1  ALU accepts the presented operation
- alu_op  out  alu_req_t  granted operation
- alu_done  in  1  ALU returns a result (in issue order)
- alu_result  in  32  returned result
- resp_valid  out  NUM_REQ  one-hot; result belongs to requester i
- resp_data  out  32  alu_result passed through
- busy  out  1  any buffer full or any operation in flight

## Operation
- Hold buffer i captures req_op when req_valid[i] & req_ready[i] are both high.
- req_ready[i] = ~buf_valid[i] | grant[i]. A buffer may be refilled in the same cycle it drains.
- Eligible requesters: buf_valid[i], and only while outstanding < FLIGHT_DEPTH.
- Grant is computed combinationally from the buffers. alu_valid = any eligible requester. alu_op = buffer of the granted requester.
- The grant commits only when alu_valid & alu_ready. On commit:
  - buf_valid[g] clears;
  - index g is pushed into the tag FIFO;
  - outstanding increments.
- On alu_done:
  - pop the tag FIFO head h;
  - resp_valid[h] = 1 and resp_data = alu_result in the same cycle;
  - outstanding decrements.
- Simultaneous commit and alu_done: outstanding is unchanged, and push and pop both occur.
- With outstanding == FLIGHT_DEPTH, alu_valid = 0. A same-cycle alu_done does not unblock the grant in that cycle; the grant resumes the following cycle.
- alu_done while the FIFO is empty is a protocol error. Outstanding saturates at 0 and resp_valid stays 0 (the verification engineer asserts this never occurs).
- FIFO read and write pointers are log2(FLIGHT_DEPTH) bits wide and wrap modulo the depth. Outstanding is log2(FLIGHT_DEPTH)+1 bits wide.
- Reset state (immediate, asynchronous):
  - buffers empty, FIFO empty, outstanding 0, round-robin pointer 0;
  - alu_valid 0, resp_valid 0, busy 0;
  - req_ready all 1; alu_op 0; resp_data follows alu_result.
- Reset mid-operation discards in-flight tags. A later alu_done is then ignored per the empty-FIFO rule.

## Timing
- Request accepted in cycle t: earliest alu_valid is t+1 (the buffer is registered).
- Response latency equals the ALU latency. The block adds zero cycles on the return path.
- Back-to-back throughput: one grant per cycle sustained while alu_ready = 1 and outstanding < FLIGHT_DEPTH.
- The round-robin pointer updates on commit only. An alu_valid without alu_ready holds the same grant and the same alu_op, which stays stable until accepted.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. After a commit to g, priority starts at (g+1) mod NUM_REQ.
- ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. The round-robin pointer register is not built.

## Structure
- The cva5_types package holds:
  - alu_req_t (packed struct);
  - alu_op_t with encodings CONSTANT=00, ADD_SUB=01, SLT=10, SHIFT=11;
  - the MAX_ALU_REQ=4 constant.
- One sub-module, alu_tag_fifo: parameterised width and depth, push/pop/empty/full, asynchronous reset. It holds the requester indices.
- Arbitration, hold buffers and counters live in the top module.

## Test plan
- Single request: req_valid[1]=1 with ADD_SUB at t0, alu_ready=1, ALU latency 1, alu_result=0x0000_0005 → alu_valid at t1, resp_valid=0b10 and resp_data=0x5 at t2.
- Contention: requesters 0 and 1 both valid every cycle for 6 cycles. With ALU_ARB_ROUND_ROBIN_EN the grants are 0,1,0,1,0,1; without it the grants are 0,0,0,0,0,0 while requester 0 stays valid.
- Backpressure: alu_ready=0 for 3 cycles → alu_op stable, req_ready[g]=0, no FIFO push. Release → exactly one commit.
- Full in-flight: FLIGHT_DEPTH=4, ALU latency 10, 5 requests → 4 commits, alu_valid low at outstanding=4. The first alu_done lets the fifth commit one cycle later, and responses return in request order.
- Simultaneous commit and alu_done with outstanding=2 → outstanding stays 2, and the tag order is correct over 20 random ops at 1-cycle ALU latency.
- Reset asserted with 3 ops in flight → all outputs reach reset values immediately, and a subsequent alu_done produces resp_valid=0.
